// File: rtl/calc_pkg.sv
// Shared key codes, FSM state encoding and small key-decode helpers for the
// keypad-driven alu sequencer.
package calc_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] KEY_ADD  = 4'hA;
    localparam logic [3:0] KEY_SUB  = 4'hB;
    localparam logic [3:0] KEY_AND  = 4'hC;
    localparam logic [3:0] KEY_OR   = 4'hD;
    localparam logic [3:0] KEY_CMP  = 4'hE;
    localparam logic [3:0] KEY_EQ   = 4'hF;
    localparam logic [3:0] ALU_IDLE = 4'h0;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_RES  = 2'd3
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_CMP);
    endfunction

endpackage

// File: rtl/calc_ctrl_if.sv
// Keypad / alu / display bundle around calc_ctrl; slave is the sequencer side,
// master is the environment (keypad decoder, alu, display driver).
interface calc_ctrl_if;
    import calc_pkg::*;

    logic              key_valid;
    logic [3:0]        key_code;
    logic [DATA_W-1:0] alu_s;
    logic              alu_zero;
    logic              alu_carry_out;

    logic [3:0]        alu_cs;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_carry_in;
    logic [DATA_W-1:0] display;
    logic              zero_flag;
    logic              carry_flag;
    logic              err;
    logic              busy;
    logic              result_valid;

    modport slave (
        input  key_valid, key_code, alu_s, alu_zero, alu_carry_out,
        output alu_cs, alu_a, alu_b, alu_carry_in, display,
               zero_flag, carry_flag, err, busy, result_valid
    );

    modport master (
        output key_valid, key_code, alu_s, alu_zero, alu_carry_out,
        input  alu_cs, alu_a, alu_b, alu_carry_in, display,
               zero_flag, carry_flag, err, busy, result_valid
    );

endinterface

// File: rtl/dec_accum.sv
// Decimal operand accumulator: value = value*10 + digit, refusing any digit
// that would push the value past the operand range (reported on ovf).
module dec_accum
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              push,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] value,
    output logic              ovf
);

    localparam int ACC_W = DATA_W + 4;
    localparam logic [ACC_W-1:0] MAX_V = ACC_W'((2 ** DATA_W) - 1);

    function automatic logic [ACC_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                  input logic [3:0]        d);
        return ACC_W'(cur) * ACC_W'(10) + ACC_W'(d);
    endfunction

    logic [ACC_W-1:0] next_w;

    assign next_w = shift_in(value, digit);
    assign ovf    = push && (next_w > MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (push && !ovf) begin
            value <= next_w[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/calc_ctrl.sv
// Keypad sequencer for the 8-bit alu: gathers A, operator, B and '=', holds the
// operands on the alu for EXEC_CYC cycles, then latches result and flags.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int EXEC_CYC    = 1,
    parameter bit CHAIN_CARRY = 1'b0
) (
    input  logic        IN_clk,
    input  logic        IN_rst_n,
    calc_ctrl_if.slave  bus
);

    localparam int CNT_W = (EXEC_CYC > 1) ? $clog2(EXEC_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYC - 1);

    state_t            state;
    logic [3:0]        op;
    logic [3:0]        last_op;
    logic              b_seen;
    logic              chain;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] result;
    logic              zero_flag_r;
    logic              carry_flag_r;
    logic              err_r;
    logic              rv_r;

    logic [DATA_W-1:0] a_val, b_val;
    logic              a_ovf, b_ovf;
    logic              key_ok, dig, opk, eq;
    logic              chained_same;

    // Keys are only decoded outside S_EXEC; strobes during execution vanish here.
    assign key_ok = bus.key_valid && (state != S_EXEC);
    assign dig    = key_ok && is_digit(bus.key_code);
    assign opk    = key_ok && is_op(bus.key_code);
    assign eq     = key_ok && (bus.key_code == KEY_EQ);

    dec_accum u_acc_a (
        .clk      (IN_clk),
        .rst_n    (IN_rst_n),
        .clr      (1'b0),
        .load     ((state == S_RES) && (dig || opk || eq)),
        .load_val (dig ? DATA_W'(bus.key_code) : result),
        .push     ((state == S_A) && dig),
        .digit    (bus.key_code),
        .value    (a_val),
        .ovf      (a_ovf)
    );

    dec_accum u_acc_b (
        .clk      (IN_clk),
        .rst_n    (IN_rst_n),
        .clr      (((state == S_A) || (state == S_RES)) && opk),
        .load     (1'b0),
        .load_val ('0),
        .push     ((state == S_B) && dig),
        .digit    (bus.key_code),
        .value    (b_val),
        .ovf      (b_ovf)
    );

    always_ff @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            state        <= S_A;
            op           <= KEY_ADD;
            last_op      <= KEY_ADD;
            b_seen       <= 1'b0;
            chain        <= 1'b0;
            cnt          <= '0;
            result       <= '0;
            zero_flag_r  <= 1'b0;
            carry_flag_r <= 1'b0;
            err_r        <= 1'b0;
            rv_r         <= 1'b0;
        end else begin
            rv_r <= 1'b0;
            if (opk) begin
                err_r <= 1'b0;
            end
            if (a_ovf || b_ovf) begin
                err_r <= 1'b1;
            end
            unique case (state)
                S_A: begin
                    if (opk) begin
                        op     <= bus.key_code;
                        b_seen <= 1'b0;
                        state  <= S_B;
                    end
                end
                S_B: begin
                    if (dig) begin
                        b_seen <= 1'b1;
                    end
                    if (opk && !b_seen) begin
                        op <= bus.key_code;
                    end
                    if (eq) begin
                        cnt   <= '0;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt == CNT_LAST) begin
                        result  <= bus.alu_s;
                        last_op <= op;
                        rv_r    <= 1'b1;
                        state   <= S_RES;
                        unique case (op)
                            KEY_CMP: begin
                                zero_flag_r  <= 1'b0;
                                carry_flag_r <= bus.alu_carry_out;
                            end
                            KEY_AND, KEY_OR: begin
                                zero_flag_r  <= bus.alu_zero;
                                carry_flag_r <= 1'b0;
                            end
                            default: begin
                                zero_flag_r  <= bus.alu_zero;
                                carry_flag_r <= bus.alu_carry_out;
                            end
                        endcase
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RES: begin
                    if (dig) begin
                        err_r        <= 1'b0;
                        carry_flag_r <= 1'b0;
                        chain        <= 1'b0;
                        state        <= S_A;
                    end else if (opk) begin
                        op     <= bus.key_code;
                        b_seen <= 1'b0;
                        chain  <= 1'b1;
                        state  <= S_B;
                    end else if (eq) begin
                        chain <= 1'b1;
                        cnt   <= '0;
                        state <= S_EXEC;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

    // A chained add->add or sub->sub may propagate the stored carry.
    assign chained_same = CHAIN_CARRY && chain && (op == last_op);

    always_comb begin
        bus.alu_carry_in = 1'b0;
        if (state == S_EXEC) begin
            if (op == KEY_SUB) begin
                bus.alu_carry_in = chained_same ? carry_flag_r : 1'b1;
            end else if (op == KEY_ADD) begin
                bus.alu_carry_in = chained_same ? carry_flag_r : 1'b0;
            end
        end
    end

    always_comb begin
        bus.display = a_val;
        unique case (state)
            S_A:          bus.display = a_val;
            S_B, S_EXEC:  bus.display = b_seen ? b_val : a_val;
            S_RES:        bus.display = result;
            default:      bus.display = a_val;
        endcase
    end

    assign bus.alu_cs       = (state == S_EXEC) ? op : ALU_IDLE;
    assign bus.alu_a        = a_val;
    assign bus.alu_b        = b_val;
    assign bus.busy         = (state == S_EXEC);
    assign bus.zero_flag    = zero_flag_r;
    assign bus.carry_flag   = carry_flag_r;
    assign bus.err          = err_r;
    assign bus.result_valid = rv_r;

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: a behavioural alu on the bus, directed
// keypad scenarios and a randomized key stream against a calculator model.
module tb_calc_ctrl;
    import calc_pkg::*;

    localparam int EXEC_CYC    = 3;
    localparam bit CHAIN_CARRY = 1'b0;

    typedef logic [3:0] kseq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_ctrl_if bus();

    calc_ctrl #(.EXEC_CYC(EXEC_CYC), .CHAIN_CARRY(CHAIN_CARRY)) dut (
        .IN_clk   (clk),
        .IN_rst_n (rst_n),
        .bus      (bus)
    );

    // Behavioural alu: carry_out is carry for add, no-borrow for sub, A<B for cmp.
    logic [8:0] alu_t;
    always_comb begin
        alu_t = '0;
        case (bus.alu_cs)
            KEY_ADD: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_carry_in};
            KEY_SUB: alu_t = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {8'd0, bus.alu_carry_in};
            KEY_AND: alu_t = {1'b0, bus.alu_a & bus.alu_b};
            KEY_OR:  alu_t = {1'b0, bus.alu_a | bus.alu_b};
            KEY_CMP: alu_t = {(bus.alu_a < bus.alu_b), bus.alu_a - bus.alu_b};
            default: alu_t = '0;
        endcase
    end
    assign bus.alu_s         = alu_t[7:0];
    assign bus.alu_zero      = (alu_t[7:0] == 8'd0);
    assign bus.alu_carry_out = alu_t[8];

    int n_pass  = 0;
    int n_total = 0;

    // Calculator model: mode 0 entering A, 1 entering B, 2 showing a result.
    int m_mode, m_a, m_b, m_op, m_last, m_res;
    bit m_bseen, m_chain, m_err, m_zf, m_cf;

    function automatic int m_disp();
        if (m_mode == 0) return m_a;
        if (m_mode == 1) return m_bseen ? m_b : m_a;
        return m_res;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_a = 0; m_b = 0; m_op = KEY_ADD; m_last = KEY_ADD; m_res = 0;
        m_bseen = 0; m_chain = 0; m_err = 0; m_zf = 0; m_cf = 0;
    endtask

    task automatic model_compute();
        int s, cin;
        bit chained;
        chained = CHAIN_CARRY && m_chain && (m_op == m_last);
        s = 0;
        if (m_op == KEY_ADD) begin
            cin = chained ? int'(m_cf) : 0;
            s = m_a + m_b + cin;
            m_res = s % 256; m_cf = (s > 255); m_zf = (m_res == 0);
        end else if (m_op == KEY_SUB) begin
            cin = chained ? int'(m_cf) : 1;
            s = m_a + (255 - m_b) + cin;
            m_res = s % 256; m_cf = (s > 255); m_zf = (m_res == 0);
        end else if (m_op == KEY_CMP) begin
            m_res = (m_a - m_b + 256) % 256; m_cf = (m_a < m_b); m_zf = 0;
        end else if (m_op == KEY_AND) begin
            m_res = m_a & m_b; m_cf = 0; m_zf = (m_res == 0);
        end else begin
            m_res = m_a | m_b; m_cf = 0; m_zf = (m_res == 0);
        end
        m_last = m_op;
    endtask

    task automatic model_key(input int k, output bit ex);
        int t;
        ex = 0;
        if (k <= 9) begin
            if (m_mode == 2) begin
                m_a = k; m_err = 0; m_cf = 0; m_chain = 0; m_mode = 0;
            end else if (m_mode == 0) begin
                t = m_a * 10 + k;
                if (t > 255) m_err = 1; else m_a = t;
            end else begin
                t = m_b * 10 + k;
                m_bseen = 1;
                if (t > 255) m_err = 1; else m_b = t;
            end
        end else if (k != 15) begin
            m_err = 0;
            if (m_mode == 0) begin
                m_op = k; m_b = 0; m_bseen = 0; m_mode = 1;
            end else if (m_mode == 1) begin
                if (!m_bseen) m_op = k;
            end else begin
                m_a = m_res; m_op = k; m_b = 0; m_bseen = 0; m_chain = 1; m_mode = 1;
            end
        end else if (m_mode != 0) begin
            if (m_mode == 2) begin
                m_a = m_res; m_chain = 1;
            end
            model_compute();
            m_mode = 2;
            ex = 1;
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int busy, output logic [3:0] cs,
                               output bit got);
        lat = 0; busy = 0; cs = ALU_IDLE; got = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.result_valid) begin
                got = 1;
                lat = i;
                break;
            end
            if (bus.alu_cs != ALU_IDLE) begin
                busy++;
                cs = bus.alu_cs;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_keys(input kseq_t q, output int nres, output int nexec,
                            output int lat, output int busy, output logic [3:0] cs);
        bit ex, got;
        nres = 0; nexec = 0; lat = 0; busy = 0; cs = ALU_IDLE;
        foreach (q[i]) begin
            press(q[i]);
            model_key(int'(q[i]), ex);
            if (ex) begin
                nexec++;
                wait_result(lat, busy, cs, got);
                if (got) nres++;
            end
        end
    endtask

    task automatic do_reset();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_reset();
        kseq_t q;
        int nres, nexec, lat, busy;
        logic [3:0] cs;
        do_reset();
        n_total++; if (bus.display !== 8'd0) $display("FAIL reset_display got %0d want 0", bus.display); else n_pass++;
        n_total++; if (bus.alu_cs !== ALU_IDLE) $display("FAIL reset_cs got %h want 0", bus.alu_cs); else n_pass++;
        n_total++; if ({bus.busy, bus.result_valid, bus.err} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {bus.busy, bus.result_valid, bus.err}); else n_pass++;
        n_total++; if ({bus.zero_flag, bus.carry_flag} !== 2'b00) $display("FAIL reset_flags got %b want 00", {bus.zero_flag, bus.carry_flag}); else n_pass++;
        n_total++; if ({bus.alu_a, bus.alu_b} !== 16'd0) $display("FAIL reset_operands got %h want 0", {bus.alu_a, bus.alu_b}); else n_pass++;
        q = {4'hF};
        run_keys(q, nres, nexec, lat, busy, cs);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL eq_in_S_A got busy=%b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_add();
        kseq_t q;
        int nres, nexec, lat, busy;
        logic [3:0] cs;
        do_reset();
        q = {4'h1, 4'h2, 4'hA, 4'h3, 4'h4, 4'hF};
        run_keys(q, nres, nexec, lat, busy, cs);
        n_total++; if (nres !== 1) $display("FAIL add_result_valid got %0d pulses want 1", nres); else n_pass++;
        n_total++; if (lat !== EXEC_CYC) $display("FAIL add_latency got %0d want %0d", lat, EXEC_CYC); else n_pass++;
        n_total++; if (busy !== EXEC_CYC) $display("FAIL add_cs_cycles got %0d want %0d", busy, EXEC_CYC); else n_pass++;
        n_total++; if (cs !== KEY_ADD) $display("FAIL add_cs got %h want A", cs); else n_pass++;
        n_total++; if (bus.display !== 8'd46) $display("FAIL add_display got %0d want 46", bus.display); else n_pass++;
        n_total++; if ({bus.zero_flag, bus.carry_flag} !== 2'b00) $display("FAIL add_flags got %b want 00", {bus.zero_flag, bus.carry_flag}); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.result_valid !== 1'b0) $display("FAIL add_pulse_width got %b want 0", bus.result_valid); else n_pass++;
    endtask

    task automatic test_add_chain();
        kseq_t q;
        int nres, nexec, lat, busy;
        logic [3:0] cs;
        do_reset();
        q = {4'h2, 4'h0, 4'h0, 4'hA, 4'h1, 4'h0, 4'h0, 4'hF};
        run_keys(q, nres, nexec, lat, busy, cs);
        n_total++; if (bus.display !== 8'd44) $display("FAIL add_wrap_display got %0d want 44", bus.display); else n_pass++;
        n_total++; if (bus.carry_flag !== 1'b1) $display("FAIL add_wrap_carry got %b want 1", bus.carry_flag); else n_pass++;
        q = {4'hA, 4'h1, 4'hF};
        run_keys(q, nres, nexec, lat, busy, cs);
        n_total++; if (nres !== 1) $display("FAIL chain_result_valid got %0d want 1", nres); else n_pass++;
        n_total++; if (bus.display !== 8'd45) $display("FAIL chain_display got %0d want 45", bus.display); else n_pass++;
        n_total++; if (bus.carry_flag !== 1'b0) $display("FAIL chain_carry got %b want 0", bus.carry_flag); else n_pass++;
    endtask

    task automatic test_sub();
        kseq_t q;
        int nres, nexec, lat, busy;
        logic [3:0] cs;
        do_reset();
        q = {4'h5, 4'hB, 4'h7, 4'hF};
        run_keys(q, nres, nexec, lat, busy, cs);
        n_total++; if (bus.display !== 8'd254) $display("FAIL sub_borrow_display got %0d want 254", bus.display); else n_pass++;
        n_total++; if ({bus.zero_flag, bus.carry_flag} !== 2'b00) $display("FAIL sub_borrow_flags got %b want 00", {bus.zero_flag, bus.carry_flag}); else n_pass++;
        q = {4'h7, 4'hB, 4'h7, 4'hF};
        run_keys(q, nres, nexec, lat, busy, cs);
        n_total++; if (cs !== KEY_SUB) $display("FAIL sub_cs got %h want B", cs); else n_pass++;
        n_total++; if (bus.display !== 8'd0) $display("FAIL sub_zero_display got %0d want 0", bus.display); else n_pass++;
        n_total++; if ({bus.zero_flag, bus.carry_flag} !== 2'b11) $display("FAIL sub_zero_flags got %b want 11", {bus.zero_flag, bus.carry_flag}); else n_pass++;
    endtask

    task automatic test_cmp_and();
        kseq_t q;
        int nres, nexec, lat, busy;
        logic [3:0] cs;
        do_reset();
        q = {4'h3, 4'hE, 4'h9, 4'hF};
        run_keys(q, nres, nexec, lat, busy, cs);
        n_total++; if (bus.display !== 8'd250) $display("FAIL cmp_display got %0d want 250", bus.display); else n_pass++;
        n_total++; if ({bus.zero_flag, bus.carry_flag} !== 2'b01) $display("FAIL cmp_flags got %b want 01", {bus.zero_flag, bus.carry_flag}); else n_pass++;
        q = {4'h1, 4'h2, 4'hC, 4'h1, 4'h0, 4'hF};
        run_keys(q, nres, nexec, lat, busy, cs);
        n_total++; if (bus.display !== 8'd8) $display("FAIL and_display got %0d want 8", bus.display); else n_pass++;
        n_total++; if (bus.carry_flag !== 1'b0) $display("FAIL and_carry got %b want 0", bus.carry_flag); else n_pass++;
    endtask

    task automatic test_err_repeat();
        kseq_t q;
        int nres, nexec, lat, busy;
        logic [3:0] cs;
        do_reset();
        q = {4'h2, 4'h5, 4'h6};
        run_keys(q, nres, nexec, lat, busy, cs);
        n_total++; if (bus.display !== 8'd25) $display("FAIL ovf_display got %0d want 25", bus.display); else n_pass++;
        n_total++; if (bus.err !== 1'b1) $display("FAIL ovf_err got %b want 1", bus.err); else n_pass++;
        q = {4'hA};
        run_keys(q, nres, nexec, lat, busy, cs);
        n_total++; if (bus.err !== 1'b0) $display("FAIL ovf_err_clear got %b want 0", bus.err); else n_pass++;
        do_reset();
        q = {4'h1, 4'h0, 4'hA, 4'h5, 4'hF};
        run_keys(q, nres, nexec, lat, busy, cs);
        n_total++; if (bus.display !== 8'd15) $display("FAIL repeat_first got %0d want 15", bus.display); else n_pass++;
        q = {4'hF};
        run_keys(q, nres, nexec, lat, busy, cs);
        n_total++; if (nres !== 1) $display("FAIL repeat_result_valid got %0d want 1", nres); else n_pass++;
        n_total++; if (bus.display !== 8'd20) $display("FAIL repeat_second got %0d want 20", bus.display); else n_pass++;
    endtask

    task automatic test_busy_keys();
        int lat, busy;
        logic [3:0] cs;
        bit got;
        do_reset();
        press(4'h1); press(4'hA); press(4'h2); press(4'hF);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h9;
        wait_result(lat, busy, cs, got);
        bus.key_valid = 1'b0;
        n_total++; if (got !== 1'b1) $display("FAIL busy_keys_result got %b want 1", got); else n_pass++;
        n_total++; if (bus.display !== 8'd3) $display("FAIL busy_keys_display got %0d want 3", bus.display); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.display !== 8'd3) $display("FAIL busy_keys_settled got %0d want 3", bus.display); else n_pass++;
    endtask

    task automatic test_reset_mid_exec();
        int pulses;
        do_reset();
        press(4'h1); press(4'hA); press(4'h2); press(4'hF);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'($urandom_range(0, 15));
        @(negedge clk);
        bus.key_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.alu_cs !== ALU_IDLE) $display("FAIL midexec_cs got %h want 0", bus.alu_cs); else n_pass++;
        n_total++; if ({bus.busy, bus.result_valid, bus.err, bus.zero_flag, bus.carry_flag} !== 5'b0)
            $display("FAIL midexec_ctrl got %b want 00000", {bus.busy, bus.result_valid, bus.err, bus.zero_flag, bus.carry_flag}); else n_pass++;
        n_total++; if ({bus.display, bus.alu_a, bus.alu_b} !== 24'd0) $display("FAIL midexec_data got %h want 0", {bus.display, bus.alu_a, bus.alu_b}); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 2 * EXEC_CYC + 4; i++) begin
            @(negedge clk);
            if (bus.result_valid) pulses++;
        end
        n_total++; if (pulses !== 0) $display("FAIL midexec_no_pulse got %0d want 0", pulses); else n_pass++;
        n_total++; if (bus.display !== 8'd0) $display("FAIL midexec_display got %0d want 0", bus.display); else n_pass++;
    endtask

    task automatic test_random();
        kseq_t q;
        int nres, nexec, lat, busy, r;
        logic [3:0] cs, k;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      k = 4'($urandom_range(0, 9));
            else if (r < 85) k = 4'($urandom_range(10, 14));
            else             k = 4'hF;
            q = {k};
            run_keys(q, nres, nexec, lat, busy, cs);
            if (nexec != 0) begin
                n_total++; if (nres !== nexec) $display("FAIL rnd_result_valid step %0d got %0d want %0d", i, nres, nexec); else n_pass++;
            end
            n_total++; if (int'(bus.display) !== m_disp()) $display("FAIL rnd_display step %0d key %h got %0d want %0d", i, k, bus.display, m_disp()); else n_pass++;
            n_total++; if (bus.err !== m_err) $display("FAIL rnd_err step %0d got %b want %b", i, bus.err, m_err); else n_pass++;
            n_total++; if ({bus.zero_flag, bus.carry_flag} !== {m_zf, m_cf}) $display("FAIL rnd_flags step %0d got %b want %b", i, {bus.zero_flag, bus.carry_flag}, {m_zf, m_cf}); else n_pass++;
        end
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        model_reset();
        test_reset();
        test_add();
        test_add_chain();
        test_sub();
        test_cmp_and();
        test_err_repeat();
        test_busy_keys();
        test_reset_mid_exec();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
